// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and reset-cause codes.
// Cause codes are only driven out when RST_SEQ_CAUSE_EN is defined.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'b00,
    ST_RELEASE = 2'b01,
    ST_DONE    = 2'b10
  } state_e;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_EXT  = 2'b01;
  localparam logic [1:0] CAUSE_SW   = 2'b10;
  localparam logic [1:0] CAUSE_BOTH = 2'b11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Request/response bundle of the reset sequencer; slave = sequencer, master = requester side.
// The rst_cause signal exists only when RST_SEQ_CAUSE_EN is defined.
interface rst_seq_ctrl_if #(
  parameter int NUM_CH = 4
);
  logic              async_rst_n;
  logic              sw_rst_req;
  logic [NUM_CH-1:0] sync_rst_n;
  logic              seq_busy;
  logic              seq_done;
`ifdef RST_SEQ_CAUSE_EN
  logic [1:0]        rst_cause;

  modport slave  (input  async_rst_n, sw_rst_req,
                  output sync_rst_n, seq_busy, seq_done, rst_cause);
  modport master (output async_rst_n, sw_rst_req,
                  input  sync_rst_n, seq_busy, seq_done, rst_cause);
`else
  modport slave  (input  async_rst_n, sw_rst_req,
                  output sync_rst_n, seq_busy, seq_done);
  modport master (output async_rst_n, sw_rst_req,
                  input  sync_rst_n, seq_busy, seq_done);
`endif
endinterface

// File: rtl/rst_sync_chain.sv
// Multi-flop synchroniser for the external reset request. Clears to 0 on reset so the
// request is seen active until the external level has propagated through every stage.
module rst_sync_chain #(
  parameter int NUM_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [NUM_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[NUM_STAGES-2:0], d_i};
  end

  assign q_o = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: merges synchronised external and software requests, stretches them to
// MIN_PULSE quiet cycles, then releases NUM_CH domain resets REL_DLY cycles apart (ch0 first).
// Optional reset-cause register is built when RST_SEQ_CAUSE_EN is defined.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int NUM_STAGES = 2,
  parameter int MIN_PULSE  = 4,
  parameter int REL_DLY    = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  rst_seq_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(max_int(MIN_PULSE, REL_DLY) + 1);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_CH-1:0]   rst_n_q, rst_n_d;
  logic                done_q, done_d;
  logic                sync_out;
  logic                ext_req;
  logic                req;
  logic                fire;

  rst_sync_chain #(.NUM_STAGES(NUM_STAGES)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (bus.async_rst_n),
    .q_o   (sync_out)
  );

  assign ext_req = ~sync_out;
  assign req     = ext_req | bus.sw_rst_req;

  // First release fires immediately on the edge after entry; later ones every REL_DLY edges.
  assign fire = (idx_q == '0) || (cnt_q == CNT_W'(REL_DLY - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    done_d  = done_q;
    if (req) begin
      // A request always wins, including over a release due on this edge.
      state_d = ST_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          rst_n_d = '0;
          done_d  = 1'b0;
          if (cnt_q == CNT_W'(MIN_PULSE - 1)) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (fire) begin
            for (int j = 0; j < NUM_CH; j++)
              if (idx_q == IDX_W'(j)) rst_n_d[j] = 1'b1;
            cnt_d = '0;
            if (idx_q == IDX_W'(NUM_CH - 1)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          rst_n_d = '1;
          done_d  = 1'b1;
        end
        default: begin
          state_d = ST_HOLD;
          rst_n_d = '0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
    end
  end

`ifdef RST_SEQ_CAUSE_EN
  logic [1:0] cause_q, cause_d;

  // Only a fresh entry into HOLD records a cause; a request held during HOLD does not.
  always_comb begin
    cause_d = cause_q;
    if (req && (state_q != ST_HOLD)) begin
      if (bus.sw_rst_req) cause_d = ext_req ? CAUSE_BOTH : CAUSE_SW;
      else                cause_d = CAUSE_EXT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cause_q <= CAUSE_POR;
    else       cause_q <= cause_d;
  end

  assign bus.rst_cause = cause_q;
`endif

  assign bus.sync_rst_n = rst_n_q;
  assign bus.seq_busy   = ~&rst_n_q;
  assign bus.seq_done   = done_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: default-parameter DUT plus a NUM_CH=1/REL_DLY=1 corner DUT on shared
// stimulus, checked each cycle against a quiet-edge-count model of the release schedule.
module tb_rst_seq_ctrl;

  localparam int NUM_CH     = 4;
  localparam int NUM_STAGES = 2;
  localparam int MIN_PULSE  = 4;
  localparam int REL_DLY    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  // Model state: synchroniser history and consecutive request-free edges since last request.
  logic [NUM_STAGES-1:0] hist = '0;
  int   k = 0;
  logic [1:0] cause_m = 2'b00;

  always #5 clk = ~clk;

  rst_seq_ctrl_if #(.NUM_CH(NUM_CH)) bus  ();
  rst_seq_ctrl_if #(.NUM_CH(1))      bus1 ();

  rst_seq_ctrl #(.NUM_CH(NUM_CH), .NUM_STAGES(NUM_STAGES), .MIN_PULSE(MIN_PULSE),
                 .REL_DLY(REL_DLY)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  rst_seq_ctrl #(.NUM_CH(1), .NUM_STAGES(NUM_STAGES), .MIN_PULSE(MIN_PULSE),
                 .REL_DLY(1)) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus1)
  );

  // Channel j is released once the quiet run reaches MIN_PULSE+1+j*REL_DLY edges.
  function automatic logic [31:0] exp_rst(input int kk, input int nch, input int mp, input int rd);
    logic [31:0] r = '0;
    for (int j = 0; j < nch; j++) r[j] = (kk >= mp + 1 + j * rd);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (k=%0d t=%0t)", tag, obs, exp, k, $time);
    end
  endtask

  task automatic step(input logic a, input logic s, input logic r);
    logic ext, req;
    logic [31:0] e4, e1;
    @(negedge clk);
    rst = r;
    bus.async_rst_n  = a;
    bus.sw_rst_req   = s;
    bus1.async_rst_n = a;
    bus1.sw_rst_req  = s;
    @(posedge clk);
    if (r) begin
      hist    = '0;
      k       = 0;
      cause_m = 2'b00;
    end else begin
      ext = ~hist[NUM_STAGES-1];
      req = ext | s;
      if (req && k >= MIN_PULSE) cause_m = s ? (ext ? 2'b11 : 2'b10) : 2'b01;
      hist = {hist[NUM_STAGES-2:0], a};
      if (req)              k = 0;
      else if (k < 100000)  k = k + 1;
    end
    #1;
    e4 = exp_rst(k, NUM_CH, MIN_PULSE, REL_DLY);
    e1 = exp_rst(k, 1, MIN_PULSE, 1);
    chk("rst_n4", {28'd0, bus.sync_rst_n}, e4);
    chk("busy4",  {31'd0, bus.seq_busy},  {31'd0, (e4[NUM_CH-1:0] != '1)});
    chk("done4",  {31'd0, bus.seq_done},  {31'd0, (e4[NUM_CH-1:0] == '1)});
    chk("rst_n1", {31'd0, bus1.sync_rst_n}, e1);
    chk("busy1",  {31'd0, bus1.seq_busy},  {31'd0, ~e1[0]});
    chk("done1",  {31'd0, bus1.seq_done},  {31'd0, e1[0]});
`ifdef RST_SEQ_CAUSE_EN
    chk("cause4", {30'd0, bus.rst_cause},  {30'd0, cause_m});
    chk("cause1", {30'd0, bus1.rst_cause}, {30'd0, cause_m});
`endif
  endtask

  initial begin
    bus.async_rst_n  = 1'b1;
    bus.sw_rst_req   = 1'b0;
    bus1.async_rst_n = 1'b1;
    bus1.sw_rst_req  = 1'b0;

    // Power-up: reset state, then absolute release edges.
    repeat (3) step(1'b1, 1'b0, 1'b1);
    chk("por_rst_n", {28'd0, bus.sync_rst_n}, 32'h0);
    chk("por_busy",  {31'd0, bus.seq_busy},  32'h1);
    repeat (6) step(1'b1, 1'b0, 1'b0);
    chk("e6_rst_n", {28'd0, bus.sync_rst_n}, 32'h0);
    step(1'b1, 1'b0, 1'b0);
    chk("e7_rst_n", {28'd0, bus.sync_rst_n}, 32'h1);
    chk("e7_done1", {31'd0, bus1.seq_done},  32'h1);
    repeat (8) step(1'b1, 1'b0, 1'b0);
    chk("e15_rst_n", {28'd0, bus.sync_rst_n}, 32'h3);
    repeat (15) step(1'b1, 1'b0, 1'b0);
    chk("e30_done", {31'd0, bus.seq_done}, 32'h0);
    step(1'b1, 1'b0, 1'b0);
    chk("e31_rst_n", {28'd0, bus.sync_rst_n}, 32'hF);
    chk("e31_done",  {31'd0, bus.seq_done},   32'h1);
    repeat (3) step(1'b1, 1'b0, 1'b0);

    // Software pulse in DONE: re-release of ch0 five edges after the pulse edge.
    step(1'b1, 1'b1, 1'b0);
    chk("sw_clear", {28'd0, bus.sync_rst_n}, 32'h0);
    repeat (4) step(1'b1, 1'b0, 1'b0);
    chk("sw_p4", {28'd0, bus.sync_rst_n}, 32'h0);
    step(1'b1, 1'b0, 1'b0);
    chk("sw_p5", {28'd0, bus.sync_rst_n}, 32'h1);
    repeat (30) step(1'b1, 1'b0, 1'b0);

    // External glitch mid-release (after 0011).
    step(1'b1, 1'b1, 1'b0);
    repeat (14) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    repeat (40) step(1'b1, 1'b0, 1'b0);

    // Request while the HOLD counter is at 2.
    step(1'b1, 1'b1, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (10) step(1'b1, 1'b0, 1'b0);

    // Collision with the ch1 release edge.
    step(1'b1, 1'b0, 1'b1);
    repeat (14) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("collide", {28'd0, bus.sync_rst_n}, 32'h0);
    repeat (12) step(1'b1, 1'b0, 1'b0);

    // Global reset mid-release.
    step(1'b1, 1'b0, 1'b1);
    chk("rst_mid_done", {31'd0, bus.seq_done}, 32'h0);
    repeat (40) step(1'b1, 1'b0, 1'b0);

    // Randomised phases: dense requests alternating with long quiet stretches.
    for (int i = 0; i < 800; i++) begin
      if ((i / 50) % 2 == 0)
        step(($urandom_range(0, 11) != 0), ($urandom_range(0, 14) == 0),
             ($urandom_range(0, 99) == 0));
      else
        step(($urandom_range(0, 59) != 0), ($urandom_range(0, 79) == 0), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
